seq_divider_32: RTL and testbench
=================================

SEQ_DIVIDER_32 -- requirements
Module: seq_divider_32

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand and result width in bits.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port start  input  1  request a division; sampled only in IDLE.
REQ-005 SHALL have port signed_op  input  1  1 = two's-complement division, 0 = unsigned; captured with start.
REQ-006 SHALL have port dividend  input  WIDTH  numerator; captured with start.
REQ-007 SHALL have port divisor  input  WIDTH  denominator; captured with start.
REQ-008 SHALL have port busy  output  1  high while a division is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse when results become valid.
REQ-010 SHALL have port quotient  output  WIDTH  result quotient; held until the next accepted start.
REQ-011 SHALL have port remainder  output  WIDTH  result remainder; held until the next accepted start.
REQ-012 SHALL have port div_by_zero  output  1  set with done when the divisor was zero; held with the results.

Function
REQ-013 SHALL implement states IDLE, RUN, FIX and DONE.
REQ-014 SHALL accept start in IDLE: capture the operands, take magnitudes when signed_op=1, clear the partial remainder, load the iteration counter with WIDTH, and go to RUN.
REQ-015 SHALL, in RUN, perform one restoring step per cycle:
- shift the partial remainder left by 1 and bring in the next dividend MSB;
- trial-subtract the |divisor| using the singleBitFullSub-equivalent borrow chain;
- keep the difference and shift in quotient bit 1 if there is no borrow, otherwise restore and shift in 0;
- decrement the counter.
REQ-016 SHALL leave RUN for FIX after exactly WIDTH steps.
REQ-017 SHALL, in FIX, negate the quotient if signed_op=1 and the operand signs differ, and negate the remainder if signed_op=1 and the dividend is negative; then go to DONE.
REQ-018 SHALL, in DONE, drive quotient and remainder, pulse done high for exactly one cycle, and return to IDLE.
REQ-019 SHALL have fixed latency: start sampled at edge k means busy is high from edge k+1 through k+WIDTH+1, done is high at edge k+WIDTH+2, and busy is low in the done cycle.
REQ-020 SHALL, on divisor==0 at start, skip RUN and FIX. Done occurs at edge k+1 with quotient=all ones, remainder=dividend, div_by_zero=1.
REQ-021 SHALL, for signed_op=1, dividend=most-negative and divisor=-1, produce quotient=most-negative and remainder=0 with no error flag, at normal latency.
REQ-022 SHALL ignore start while busy=1 or in the DONE cycle; captured operands SHALL NOT be disturbed by input changes after acceptance.
REQ-023 SHALL accept a start in the first IDLE cycle following done (back-to-back operation).
REQ-024 SHALL clear div_by_zero on every accepted start.
REQ-025 SHALL satisfy quotient*divisor+remainder==dividend (mod 2^WIDTH) and |remainder|<|divisor| for every nonzero divisor.

Reset
REQ-026 SHALL, when rst_n=0 at a clock edge, force state IDLE, busy=0, done=0, div_by_zero=0, quotient=0, remainder=0 and counter=0, regardless of state.
REQ-027 SHALL abandon any in-progress division on reset and SHALL NOT emit done for it.
REQ-028 SHALL let the first clk edge with rst_n=1 accept a start.

Verification
REQ-029 SHALL cover unsigned 100/7, start at edge 0 -> done at edge 34, quotient=14, remainder=2, div_by_zero=0.
REQ-030 SHALL cover signed 0xFFFFFFF9 / 0x00000002 (-7/2) -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF, done at edge 34.
REQ-031 SHALL cover 5/0 (either mode) -> done at edge 1, quotient=0xFFFFFFFF, remainder=5, div_by_zero=1.
REQ-032 SHALL cover signed 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0, div_by_zero=0.
REQ-033 SHALL cover rst_n=0 at edge 10 of a division -> busy=0 at edge 11, all outputs zero, and no done pulse within the next 40 cycles.
REQ-034 SHALL cover start re-asserted with new operands at edge 5 of a division -> ignored; the original result is delivered at edge 34.

Source files
------------

// File: rtl/seq_divider_32.sv
// Sequential restoring divider: one quotient bit per clock, signed or unsigned,
// with a fixed latency of WIDTH+2 cycles from an accepted start to the done pulse.
module seq_divider_32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic [1:0]       dbg_state
);

  // Handshake: start is taken only while idle (busy=0, done=0); operands are
  // captured on that edge. busy covers RUN/FIX, done is a single-cycle pulse,
  // and results/div_by_zero stay stable until the next accepted start.

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] dvd_r;
  logic [WIDTH-1:0] dsr_r;
  logic [WIDTH-1:0] prem_r;
  logic [WIDTH-1:0] quo_r;
  logic [CW-1:0]    cnt_r;
  logic             neg_q_r;
  logic             neg_r_r;

  logic             accept;
  logic             zero_div;
  logic [WIDTH-1:0] abs_dvd;
  logic [WIDTH-1:0] abs_dsr;
  logic [WIDTH:0]   trial_a;
  logic [WIDTH-1:0] diff;
  logic             b_chain;
  logic             borrow;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  assign busy      = (state == S_RUN) || (state == S_FIX);
  assign done      = (state == S_DONE);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    zero_div  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          accept = 1'b1;
          if (divisor == '0) begin
            zero_div  = 1'b1;
            state_nxt = S_DONE;
          end else begin
            state_nxt = S_RUN;
          end
        end
      end
      S_RUN:   if (cnt_r == CW'(1)) state_nxt = S_FIX;
      S_FIX:   state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Magnitudes; the most-negative value maps onto 2^(WIDTH-1), which is exact unsigned.
  always_comb begin
    abs_dvd = (signed_op && dividend[WIDTH-1]) ? ('0 - dividend) : dividend;
    abs_dsr = (signed_op && divisor[WIDTH-1])  ? ('0 - divisor)  : divisor;
  end

  // Trial subtraction as a ripple of single-bit full subtractors; the top bit of
  // the shifted remainder only has to absorb the borrow.
  always_comb begin
    trial_a = {prem_r, dvd_r[WIDTH-1]};
    diff    = '0;
    b_chain = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      diff[i] = trial_a[i] ^ dsr_r[i] ^ b_chain;
      b_chain = (~trial_a[i] & dsr_r[i]) | (~(trial_a[i] ^ dsr_r[i]) & b_chain);
    end
    borrow = ~trial_a[WIDTH] & b_chain;
  end

  always_comb begin
    q_fix = neg_q_r ? ('0 - quo_r)  : quo_r;
    r_fix = neg_r_r ? ('0 - prem_r) : prem_r;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dvd_r       <= '0;
      dsr_r       <= '0;
      prem_r      <= '0;
      quo_r       <= '0;
      cnt_r       <= '0;
      neg_q_r     <= 1'b0;
      neg_r_r     <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      if (accept) begin
        dvd_r       <= abs_dvd;
        dsr_r       <= abs_dsr;
        prem_r      <= '0;
        quo_r       <= '0;
        neg_q_r     <= signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
        neg_r_r     <= signed_op & dividend[WIDTH-1];
        div_by_zero <= zero_div;
        if (zero_div) begin
          cnt_r     <= '0;
          quotient  <= '1;
          remainder <= dividend;
        end else begin
          cnt_r     <= CW'(WIDTH);
        end
      end
      if (state == S_RUN) begin
        prem_r <= borrow ? trial_a[WIDTH-1:0] : diff;
        quo_r  <= {quo_r[WIDTH-2:0], ~borrow};
        dvd_r  <= {dvd_r[WIDTH-2:0], 1'b0};
        cnt_r  <= cnt_r - CW'(1);
      end
      if (state == S_FIX) begin
        quotient  <= q_fix;
        remainder <= r_fix;
      end
    end
  end

endmodule

// File: tb/tb_seq_divider_32.sv
// Directed bench for seq_divider_32: hand-computed results, latency, start
// filtering while busy/done, reset abort and back-to-back operation.
module tb_seq_divider_32;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        signed_op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;
  logic [1:0]  dbg_state;

  int n_cmp;
  int n_fail;

  // Edges counted after the start edge until done is seen just after an edge.
  localparam int LAT_RUN  = 33;
  localparam int LAT_ZERO = 0;

  seq_divider_32 #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .signed_op  (signed_op),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero),
    .dbg_state  (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_div(input string tag, input logic sop,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er,
                         input logic edz, input int elat);
    int cyc;
    start     = 1'b1;
    signed_op = sop;
    dividend  = a;
    divisor   = b;
    tick();
    start     = 1'b0;
    dividend  = $urandom;
    divisor   = $urandom;
    signed_op = 1'($urandom_range(0, 1));
    check({tag, ":busy_after_start"}, 64'(busy), 64'(elat != 0));
    cyc = 0;
    while (done !== 1'b1 && cyc < 100) begin
      tick();
      cyc++;
      // start pulsed with fresh operands at edge 5 of the division
      if (cyc == 4) begin
        start    = 1'b1;
        dividend = $urandom;
        divisor  = $urandom;
      end
      if (cyc == 6) start = 1'b0;
    end
    check({tag, ":latency"},     64'(cyc),         64'(elat));
    check({tag, ":quotient"},    64'(quotient),    64'(eq));
    check({tag, ":remainder"},   64'(remainder),   64'(er));
    check({tag, ":div_by_zero"}, 64'(div_by_zero), 64'(edz));
    check({tag, ":busy_in_done"}, 64'(busy),       64'd0);
    // start during the done cycle must be ignored
    start    = 1'b1;
    dividend = $urandom;
    divisor  = $urandom;
    tick();
    start = 1'b0;
    check({tag, ":done_pulse_1cyc"}, 64'(done),      64'd0);
    check({tag, ":idle_after_done"}, 64'(dbg_state), 64'd0);
    check({tag, ":quotient_held"},   64'(quotient),  64'(eq));
  endtask

  initial begin
    logic seen_done;
    n_cmp     = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    signed_op = 1'b0;
    dividend  = '0;
    divisor   = '0;
    tick();
    tick();
    tick();
    check("reset:busy",        64'(busy),        64'd0);
    check("reset:done",        64'(done),        64'd0);
    check("reset:quotient",    64'(quotient),    64'd0);
    check("reset:remainder",   64'(remainder),   64'd0);
    check("reset:div_by_zero", 64'(div_by_zero), 64'd0);
    check("reset:state",       64'(dbg_state),   64'd0);

    // first edge with rst_n=1 carries the start
    rst_n = 1'b1;
    run_div("u100_7",   1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, LAT_RUN);
    run_div("s-7_2",    1'b1, 32'hFFFF_FFF9,  32'h0000_0002,  32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0, LAT_RUN);
    run_div("u5_0",     1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1, LAT_ZERO);
    run_div("s5_0",     1'b1, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1, LAT_ZERO);
    run_div("smin_-1",  1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0, LAT_RUN);
    run_div("umax_1",   1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0, LAT_RUN);
    run_div("umax_max", 1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0, LAT_RUN);
    run_div("u7_9",     1'b0, 32'd7,          32'd9,          32'd0,          32'd7,          1'b0, LAT_RUN);
    run_div("s7_-2",    1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0, LAT_RUN);
    run_div("s-8_-3",   1'b1, 32'hFFFF_FFF8,  32'hFFFF_FFFD,  32'd2,          32'hFFFF_FFFE,  1'b0, LAT_RUN);
    run_div("u2^31_3",  1'b0, 32'h8000_0000,  32'd3,          32'h2AAA_AAAA,  32'd2,          1'b0, LAT_RUN);
    run_div("u_max_2^31", 1'b0, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1,          32'h7FFF_FFFF,  1'b0, LAT_RUN);

    // reset at edge 10 of a division abandons it
    start     = 1'b1;
    signed_op = 1'b0;
    dividend  = 32'd100;
    divisor   = 32'd7;
    tick();
    start = 1'b0;
    for (int i = 1; i < 10; i++) tick();
    check("abort:busy_before_reset", 64'(busy), 64'd1);
    rst_n = 1'b0;
    tick();
    check("abort:busy",        64'(busy),        64'd0);
    check("abort:done",        64'(done),        64'd0);
    check("abort:quotient",    64'(quotient),    64'd0);
    check("abort:remainder",   64'(remainder),   64'd0);
    check("abort:div_by_zero", 64'(div_by_zero), 64'd0);
    check("abort:state",       64'(dbg_state),   64'd0);
    rst_n     = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done === 1'b1) seen_done = 1'b1;
    end
    check("abort:no_done", 64'(seen_done), 64'd0);

    run_div("after_abort", 1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, LAT_RUN);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
